// File: rtl/cookie_ctrl_pkg.sv
// cookie_ctrl_pkg
//   Shared definitions for the cookie mesh sequencer: the controller state
//   encoding and the default word width / mesh latency.
//   Optional feature macro used by the top: COOKIE_CTRL_PARITY_EN.
package cookie_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cookie_ctrl_state_t;

   localparam int COOKIE_WIDTH_DEF   = 8;
   localparam int COOKIE_LATENCY_DEF = 7;

endpackage

// File: rtl/cookie_ctrl_capture.sv
// cookie_ctrl_capture
//   WIDTH-bit serial-in capture register. Each write stores one bit at the
//   given index; clear zeroes the whole word and has priority over write.
//   The look-ahead word (value after the current edge) is exported so the
//   top can latch a complete result on the same edge as the last bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : zero the word at the next edge
//   we          : store bit_in at position idx at the next edge
//   idx         : bit position to write
//   bit_in      : serial bit to store
//   data_next   : word value after the next edge
module cookie_ctrl_capture
   import cookie_ctrl_pkg::*;
#(
   parameter int WIDTH = COOKIE_WIDTH_DEF,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic             bit_in,
   output logic [WIDTH-1:0] data_next
);

   logic [WIDTH-1:0] word_r;
   logic [WIDTH-1:0] word_next_s;
   logic [WIDTH-1:0] mask_s;

   // One-hot mask of the bit being written this cycle.
   always_comb begin
      mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
   end

   // Next word: clear wins, otherwise replace the addressed bit.
   always_comb begin
      word_next_s = word_r;
      if (clr) begin
         word_next_s = {WIDTH{1'b0}};
      end else if (we) begin
         word_next_s = (word_r & ~mask_s) | (bit_in ? mask_s : {WIDTH{1'b0}});
      end else begin
         word_next_s = word_r;
      end
   end

   // Capture storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r <= {WIDTH{1'b0}};
      end else begin
         word_r <= word_next_s;
      end
   end

   assign data_next = word_next_s;

endmodule

// File: rtl/cookie_ctrl.sv
// cookie_ctrl
//   Sequencer for the cookie random-bit mesh. Accepts a seed word, shifts it
//   LSB-first into the mesh with en high, keeps en high for LATENCY more
//   cycles to flush the pipeline while capturing the mesh output, then
//   presents the captured word on a valid/ready output.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data: seed handshake
//   out_valid/out_ready/out_data : result handshake
//   busy                     : job in progress
//   cookie_en, cookie_rbit   : mesh enable and serial input
//   cookie_rbit_o            : mesh serial output
//   out_parity               : XOR of out_data (only with COOKIE_CTRL_PARITY_EN)
// Optional feature macro: COOKIE_CTRL_PARITY_EN
module cookie_ctrl
   import cookie_ctrl_pkg::*;
#(
   parameter int WIDTH   = COOKIE_WIDTH_DEF,
   parameter int LATENCY = COOKIE_LATENCY_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             cookie_en,
   output logic             cookie_rbit,
`ifdef COOKIE_CTRL_PARITY_EN
   output logic             out_parity,
`endif
   input  logic             cookie_rbit_o
);

   localparam int CNT_W = $clog2(WIDTH + LATENCY);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH + LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] CNT_WID  = CNT_W'(WIDTH);

   function automatic logic calc_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   cookie_ctrl_state_t state_r;
   cookie_ctrl_state_t state_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   seed_r;
   logic [WIDTH-1:0]   out_data_r;
   logic [WIDTH-1:0]   seed_sh_s;
   logic [WIDTH-1:0]   cap_next_s;
   logic               accept_s;
   logic               run_last_s;
   logic               cap_we_s;
   logic [IDX_W-1:0]   cap_idx_s;

   assign accept_s   = (state_r == IDLE) && in_valid;
   assign run_last_s = (state_r == RUN) && (cnt_r == CNT_LAST);
   assign seed_sh_s  = seed_r >> cnt_r;
   // The mesh output for seed bit k emerges LATENCY enabled cycles later.
   assign cap_we_s   = (state_r == RUN) && (cnt_r >= CNT_LAT);
   assign cap_idx_s  = IDX_W'(cnt_r - CNT_LAT);

   cookie_ctrl_capture #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_capture (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (accept_s),
      .we        (cap_we_s),
      .idx       (cap_idx_s),
      .bit_in    (cookie_rbit_o),
      .data_next (cap_next_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = in_valid ? RUN : IDLE;
         RUN:     state_next_s = (cnt_r == CNT_LAST) ? DONE : RUN;
         DONE:    state_next_s = out_ready ? IDLE : DONE;
         default: state_next_s = IDLE;
      endcase
   end

   // Seed latch and bit counter; the counter stops at its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_r <= {WIDTH{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         seed_r <= in_data;
         cnt_r  <= {CNT_W{1'b0}};
      end else if ((state_r == RUN) && !run_last_s) begin
         cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r  <= cnt_r;
      end
   end

   // Result word: loaded with the look-ahead capture value on DONE entry so
   // the final sampled bit is included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r <= {WIDTH{1'b0}};
      end else if (run_last_s) begin
         out_data_r <= cap_next_s;
      end else begin
         out_data_r <= out_data_r;
      end
   end

`ifdef COOKIE_CTRL_PARITY_EN
   logic out_parity_r;

   // Parity of the result word, same timing as out_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_parity_r <= 1'b0;
      end else if (run_last_s) begin
         out_parity_r <= calc_parity(cap_next_s);
      end else begin
         out_parity_r <= out_parity_r;
      end
   end

   assign out_parity = out_parity_r;
`endif

   // Output decode from state and counter only (no input-to-mesh path).
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      cookie_en   = 1'b0;
      cookie_rbit = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         RUN: begin
            cookie_en   = 1'b1;
            cookie_rbit = (cnt_r < CNT_WID) ? seed_sh_s[0] : 1'b0;
         end
         DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign out_data = out_data_r;

endmodule

// File: tb/tb_cookie_ctrl.sv
// tb_cookie_ctrl
//   Directed bench for cookie_ctrl. Two instances: default parameters
//   (WIDTH=8, LATENCY=7) and WIDTH=1, LATENCY=1. Each mesh is modelled as a
//   LATENCY-deep shift register that advances only while cookie_en is high.
//   Outputs are sampled on the falling clock edge.
module tb_cookie_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, busy, en, rbit, rbit_o;
   logic [7:0] in_data, out_data;
   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
   logic       en_b, rbit_b, rbit_o_b;
   logic [0:0] in_data_b, out_data_b;
`ifdef COOKIE_CTRL_PARITY_EN
   logic       par, par_b;
`endif

   logic [6:0] mesh_a;
   logic       mesh_b;
   logic [14:0] exp_rbit;

   int n_cmp;
   int n_fail;

   always #5 clk = ~clk;

   cookie_ctrl #(.WIDTH(8), .LATENCY(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .cookie_en(en), .cookie_rbit(rbit),
`ifdef COOKIE_CTRL_PARITY_EN
      .out_parity(par),
`endif
      .cookie_rbit_o(rbit_o)
   );

   cookie_ctrl #(.WIDTH(1), .LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .busy(busy_b), .cookie_en(en_b), .cookie_rbit(rbit_b),
`ifdef COOKIE_CTRL_PARITY_EN
      .out_parity(par_b),
`endif
      .cookie_rbit_o(rbit_o_b)
   );

   // Mesh models: pipeline advancing only when enabled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mesh_a <= 7'd0;
         mesh_b <= 1'b0;
      end else begin
         if (en)   mesh_a <= {mesh_a[5:0], rbit};
         if (en_b) mesh_b <= rbit_b;
      end
   end
   assign rbit_o   = mesh_a[6];
   assign rbit_o_b = mesh_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      in_valid_b = 1'b0; in_data_b = 1'b0; out_ready_b = 1'b0;
      exp_rbit = 15'b000_0000_1010_0101;
      nxt(3);
      rst_n = 1'b1;

      // Reset values
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_en", {31'd0, en}, 32'd0);
      check("rst_rbit", {31'd0, rbit}, 32'd0);
      check("rst_b_in_ready", {31'd0, in_ready_b}, 32'd1);
      check("rst_b_out_data", {31'd0, out_data_b}, 32'd0);
`ifdef COOKIE_CTRL_PARITY_EN
      check("rst_parity", {31'd0, par}, 32'd0);
`endif

      // Idle for 20 cycles
      for (int i = 0; i < 20; i++) begin
         nxt(1);
         check("idle_in_ready", {31'd0, in_ready}, 32'd1);
         check("idle_out_valid", {31'd0, out_valid}, 32'd0);
         check("idle_en", {31'd0, en}, 32'd0);
      end

      // Single job 0xA5, accepted at cycle T
      in_valid = 1'b1; in_data = 8'hA5;
      nxt(1);                                   // T+1
      in_valid = 1'b0;
      for (int k = 0; k < 15; k++) begin
         check("run_en", {31'd0, en}, 32'd1);
         check("run_rbit", {31'd0, rbit}, {31'd0, exp_rbit[k]});
         check("run_out_valid", {31'd0, out_valid}, 32'd0);
         check("run_in_ready", {31'd0, in_ready}, 32'd0);
         nxt(1);
      end
      // T+16
      check("done_out_valid", {31'd0, out_valid}, 32'd1);
      check("done_out_data", {24'd0, out_data}, 32'h0000_00A5);
      check("done_en", {31'd0, en}, 32'd0);
      check("done_busy", {31'd0, busy}, 32'd1);
`ifdef COOKIE_CTRL_PARITY_EN
      check("done_parity_a5", {31'd0, par}, 32'd0);
`endif

      // Backpressure: new seed offered while result is held
      in_valid = 1'b1; in_data = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         nxt(1);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_data", {24'd0, out_data}, 32'h0000_00A5);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;                         // DONE with out_ready at D
      nxt(1);                                   // D+1: IDLE, seed accepted
      check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_keep_out_data", {24'd0, out_data}, 32'h0000_00A5);
      nxt(1);                                   // T'+1
      in_valid = 1'b0;
      check("bp_run_busy", {31'd0, busy}, 32'd1);
      check("bp_run_en", {31'd0, en}, 32'd1);
      check("bp_run_rbit0", {31'd0, rbit}, 32'd0);
      nxt(14);                                  // T'+15
      check("bp_last_run_en", {31'd0, en}, 32'd1);
      nxt(1);                                   // T'+16
      check("3c_out_valid", {31'd0, out_valid}, 32'd1);
      check("3c_out_data", {24'd0, out_data}, 32'h0000_003C);
`ifdef COOKIE_CTRL_PARITY_EN
      check("3c_parity", {31'd0, par}, 32'd0);
`endif
      nxt(1);
      check("3c_one_cycle_valid", {31'd0, out_valid}, 32'd0);
      check("3c_idle_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back: 0xFF at A, 0x01 at A+17
      in_valid = 1'b1; in_data = 8'hFF;
      nxt(1);                                   // A+1
      check("b2b_busy", {31'd0, busy}, 32'd1);
      in_data = 8'h01;
      nxt(15);                                  // A+16
      check("ff_out_valid", {31'd0, out_valid}, 32'd1);
      check("ff_out_data", {24'd0, out_data}, 32'h0000_00FF);
      check("ff_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef COOKIE_CTRL_PARITY_EN
      check("ff_parity", {31'd0, par}, 32'd0);
`endif
      nxt(1);                                   // A+17: second accept
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_out_valid", {31'd0, out_valid}, 32'd0);
      nxt(1);                                   // A+18
      in_valid = 1'b0;
      check("b2b_run2_en", {31'd0, en}, 32'd1);
      check("b2b_run2_rbit", {31'd0, rbit}, 32'd1);
      nxt(15);                                  // A+33
      check("01_out_valid", {31'd0, out_valid}, 32'd1);
      check("01_out_data", {24'd0, out_data}, 32'h0000_0001);
`ifdef COOKIE_CTRL_PARITY_EN
      check("01_parity", {31'd0, par}, 32'd1);
`endif
      nxt(1);
      check("01_idle", {31'd0, busy}, 32'd0);

      // Reset in the middle of RUN (cnt = 5)
      in_valid = 1'b1; in_data = 8'h77;
      nxt(1);                                   // T+1, cnt=0
      in_valid = 1'b0;
      nxt(5);                                   // cnt=5
      check("mid_en_before", {31'd0, en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_en_async", {31'd0, en}, 32'd0);
      check("mid_busy_async", {31'd0, busy}, 32'd0);
      check("mid_out_data_async", {24'd0, out_data}, 32'd0);
      nxt(1);
      rst_n = 1'b1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_out_data", {24'd0, out_data}, 32'd0);
      check("post_rst_en", {31'd0, en}, 32'd0);
      in_valid = 1'b1; in_data = 8'h5A;
      nxt(1);
      in_valid = 1'b0;
      nxt(15);                                  // T+16
      check("5a_out_valid", {31'd0, out_valid}, 32'd1);
      check("5a_out_data", {24'd0, out_data}, 32'h0000_005A);
`ifdef COOKIE_CTRL_PARITY_EN
      check("5a_parity", {31'd0, par}, 32'd0);
`endif
      nxt(1);

      // WIDTH=1, LATENCY=1 instance, seed 1
      in_valid_b = 1'b1; in_data_b = 1'b1; out_ready_b = 1'b1;
      nxt(1);                                   // T+1
      in_valid_b = 1'b0;
      check("w1_en_1", {31'd0, en_b}, 32'd1);
      check("w1_rbit_1", {31'd0, rbit_b}, 32'd1);
      nxt(1);                                   // T+2
      check("w1_en_2", {31'd0, en_b}, 32'd1);
      check("w1_rbit_2", {31'd0, rbit_b}, 32'd0);
      check("w1_no_valid_2", {31'd0, out_valid_b}, 32'd0);
      nxt(1);                                   // T+3
      check("w1_out_valid", {31'd0, out_valid_b}, 32'd1);
      check("w1_out_data", {31'd0, out_data_b}, 32'd1);
      check("w1_en_done", {31'd0, en_b}, 32'd0);
`ifdef COOKIE_CTRL_PARITY_EN
      check("w1_parity", {31'd0, par_b}, 32'd1);
`endif
      nxt(1);
      check("w1_idle", {31'd0, in_ready_b}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
